multicycle_ctrl: RTL



---
 rtl/multicycle_ctrl_if.sv | 12 +
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Unified memory port shared by instruction fetch and data access.
// The controller drives the request side; memory answers with mem_ready.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_ready;
  logic iord;
  logic memRead;
  logic memWrite;

  modport master (output mem_req, iord, memRead, memWrite, input mem_ready);
  modport slave  (input mem_req, iord, memRead, memWrite, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-subset datapath.
// Control outputs are decoded from state and the opcode latched at fetch.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  multicycle_ctrl_if.master mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic             regDst,
  output logic             jump,
  output logic             branch,
  output logic             memToReg,
  output logic [3:0]       aluOp,
  output logic             aluSrc,
  output logic             regWrite,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             fetch_busy_q, fetch_busy_d;
  logic             mem_req_c, iord_c, mem_read_c, mem_write_c, retire;

  logic is_r, is_lui, is_bsw, is_lw, is_sw, is_imm, is_br, is_j, legal;
  logic [3:0] alu_code;

  always_comb begin
    is_r   = (opcode_q == 6'b000000);
    is_lui = (opcode_q == 6'b001111);
    is_bsw = (opcode_q == 6'b011111);
    is_lw  = (opcode_q == 6'b100011);
    is_sw  = (opcode_q == 6'b101011);
    is_j   = (opcode_q == 6'b000010);
    is_imm = (opcode_q[5:3] == 3'b001) && (opcode_q != 6'b001111);
    is_br  = (opcode_q == 6'b000011) || (opcode_q == 6'b000100) ||
             (opcode_q == 6'b000001) || (opcode_q == 6'b000101);
    legal  = is_r | is_lui | is_bsw | is_lw | is_sw | is_j | is_imm | is_br;
    case (opcode_q)
      6'b000000: alu_code = 4'b0010;
      6'b001111: alu_code = 4'b1001;
      6'b011111: alu_code = 4'b1111;
      6'b001100: alu_code = 4'b0100;
      6'b001101: alu_code = 4'b0101;
      6'b001110: alu_code = 4'b0111;
      6'b001010, 6'b001011: alu_code = 4'b0110;
      6'b000011: alu_code = 4'b1000;
      6'b000100: alu_code = 4'b0001;
      6'b000001: alu_code = 4'b0011;
      6'b000101: alu_code = 4'b1011;
      default:   alu_code = 4'b0000;
    endcase
  end

  always_comb begin
    state_d = state_q;  opcode_d = opcode_q;  fetch_busy_d = fetch_busy_q;
    mem_req_c = 1'b0;  iord_c = 1'b0;  mem_read_c = 1'b0;  mem_write_c = 1'b0;
    ir_write = 1'b0;  pc_write = 1'b0;  regDst = 1'b0;  jump = 1'b0;
    branch = 1'b0;  memToReg = 1'b0;  aluOp = 4'b0000;  aluSrc = 1'b0;
    regWrite = 1'b0;  illegal = 1'b0;  retire = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Once a fetch has been requested it is held even if run drops.
        if (run || fetch_busy_q) begin
          mem_req_c  = 1'b1;
          mem_read_c = 1'b1;
          if (mem.mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            opcode_d     = opcode;
            fetch_busy_d = 1'b0;
            state_d      = S_DECODE;
          end else begin
            fetch_busy_d = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (is_j) begin
          jump = 1'b1;  pc_write = 1'b1;  retire = 1'b1;  state_d = S_FETCH;
        end else if (!legal) begin
          illegal = 1'b1;  state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        aluOp  = alu_code;
        aluSrc = is_imm | is_lui | is_lw | is_sw;
        if (is_br) begin
          branch = 1'b1;  retire = 1'b1;  state_d = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_c   = 1'b1;
        iord_c      = 1'b1;
        aluSrc      = 1'b1;
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (mem.mem_ready) begin
          if (is_sw) begin
            retire = 1'b1;  state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        regDst   = is_r | is_bsw;
        memToReg = is_lw;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    retired_d = retired_q + CNT_W'(retire);
    // Reset masks every control output, including mid-handshake.
    if (rst) begin
      mem_req_c = 1'b0;  iord_c = 1'b0;  mem_read_c = 1'b0;  mem_write_c = 1'b0;
      ir_write = 1'b0;  pc_write = 1'b0;  regDst = 1'b0;  jump = 1'b0;
      branch = 1'b0;  memToReg = 1'b0;  aluOp = 4'b0000;  aluSrc = 1'b0;
      regWrite = 1'b0;  illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      opcode_q     <= 6'd0;
      retired_q    <= '0;
      fetch_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      retired_q    <= retired_d;
      fetch_busy_q <= fetch_busy_d;
    end
  end

  assign mem.mem_req  = mem_req_c;
  assign mem.iord     = iord_c;
  assign mem.memRead  = mem_read_c;
  assign mem.memWrite = mem_write_c;
  assign state        = state_q;
  assign retired      = retired_q;
endmodule
